parity_tx: RTL and testbench

Serial frame transmitter that pairs with the team's serial parity checker. It accepts a parallel data word over a valid/ready handshake and shifts it out on a single line as one frame: start bit, data LSB-first, parity bit, stop bit. It sits at the transmit end of the serial parity link, and its `tx` output drives the checker's input.

---
 rtl/parity_pkg.sv | 7 +
 rtl/parity_tx_bit_timer.sv | 17 +
 rtl/parity_tx.sv | 65 ++++++
 tb/tb_parity_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared state encoding and constants for the serial parity link.
package parity_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int FRAME_OVERHEAD = 3;
    localparam logic EVEN = 1'b0;
    localparam logic ODD = 1'b1;
endpackage

// File: rtl/parity_tx_bit_timer.sv
// bit_timer: divides the clock into bit periods; tick marks the last cycle of each period.
module bit_timer #(
    parameter int BAUD_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = run && cnt == CW'(BAUD_DIV - 1);
    always_ff @(posedge clk) begin
        if (rst || !run) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/parity_tx.sv
// parity_tx: frames a parallel word as start, LSB-first data, parity and stop bits on tx.
module parity_tx
    import parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PARITY_ODD = 0,
    parameter int BAUD_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              par
);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic MODE = (PARITY_ODD != 0) ? ODD : EVEN;
    state_t state, nxt;
    logic tick, xfer, last_bit, par_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [IW-1:0] idx;
    bit_timer #(.BAUD_DIV(BAUD_DIV)) u_timer (
        .clk(clk),
        .rst(rst),
        .run(busy),
        .tick(tick)
    );
    // Ready in the final stop cycle lets the next frame start with no idle gap.
    assign in_ready = state == IDLE || (state == STOP && tick);
    assign xfer = in_valid && in_ready;
    assign last_bit = idx == IW'(DATA_W - 1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = xfer ? START : IDLE;
            START:   nxt = tick ? DATA : START;
            DATA:    nxt = (tick && last_bit) ? PARITY : DATA;
            PARITY:  nxt = tick ? STOP : PARITY;
            STOP:    nxt = tick ? (xfer ? START : IDLE) : STOP;
            default: nxt = IDLE;
        endcase
    end
    assign sh_nxt = xfer ? in_data : (state == DATA && tick) ? sh >> 1 : sh;
    assign par_nxt = xfer ? ((^in_data) ^ MODE) : (nxt == IDLE) ? 1'b0 : par;
    // tx is registered from the next state so each bit appears the cycle it is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            sh <= '0;
            par <= 1'b0;
            tx <= 1'b1;
            busy <= 1'b0;
        end else begin
            state <= nxt;
            sh <= sh_nxt;
            par <= par_nxt;
            busy <= nxt != IDLE;
            tx <= nxt == START ? 1'b0 : nxt == DATA ? sh_nxt[0] : nxt == PARITY ? par_nxt : 1'b1;
            if (state == DATA && tick) idx <= last_bit ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_tx.sv
// tb_parity_tx: three configurations (default, odd parity, BAUD_DIV=3) checked against a frame-queue model.
module tb_parity_tx;
    localparam int DW = 4;
    logic clk = 1'b0;
    logic vld[3];
    logic [DW-1:0] dat[3];
    logic rs[3];
    logic tx_o[3], busy_o[3], par_o[3], rdy_o[3];
    logic [1:0] q[3][$];
    int pass_n = 0, tot_n = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        parity_tx #(.DATA_W(DW), .PARITY_ODD(g == 1 ? 1 : 0), .BAUD_DIV(g == 2 ? 3 : 1)) dut (
            .clk(clk),
            .rst(rs[g]),
            .in_valid(vld[g]),
            .in_data(dat[g]),
            .in_ready(rdy_o[g]),
            .tx(tx_o[g]),
            .busy(busy_o[g]),
            .par(par_o[g])
        );
    end
    function automatic int bd(input int i);
        return i == 2 ? 3 : 1;
    endfunction
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask
    // The model keeps the remaining {line bit, parity} per cycle of the frame in flight.
    task automatic model_edge(input int i);
        logic xf, p, bv;
        if (rs[i]) begin
            q[i].delete();
            return;
        end
        xf = vld[i] && q[i].size() <= 1;
        if (q[i].size() > 0) void'(q[i].pop_front());
        if (xf) begin
            p = (^dat[i]) ^ (i == 1);
            for (int b = 0; b < DW + 3; b++) begin
                bv = b == 0 ? 1'b0 : b <= DW ? dat[i][b-1] : b == DW + 1 ? p : 1'b1;
                repeat (bd(i)) q[i].push_back({bv, p});
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tx%0d", i), 32'(tx_o[i]), 32'(q[i].size() > 0 ? q[i][0][1] : 1'b1));
            check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(q[i].size() > 0));
            check($sformatf("par%0d", i), 32'(par_o[i]), 32'(q[i].size() > 0 ? q[i][0][0] : 1'b0));
            check($sformatf("ready%0d", i), 32'(rdy_o[i]), 32'(q[i].size() <= 1));
        end
    endtask
    initial begin
        logic [6:0] s0, s1;
        logic [23:0] s2;
        logic [13:0] bt, br;
        int nb;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
            rs[i] = 1'b1;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) rs[i] = 1'b0;
        check("rst_tx", 32'(tx_o[0]), 32'd1);
        check("rst_ready", 32'(rdy_o[0]), 32'd1);
        repeat (20) step();
        check("idle_tx", 32'(tx_o[0]), 32'd1);
        check("idle_busy", 32'(busy_o[2]), 32'd0);
        vld = '{1'b1, 1'b1, 1'b1};
        dat = '{4'b0100, 4'b0000, 4'b0110};
        nb = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 1) begin
                vld = '{1'b0, 1'b0, 1'b0};
                check("par_even", 32'(par_o[0]), 32'd1);
                check("par_odd", 32'(par_o[1]), 32'd1);
            end
            if (c <= 7) begin
                s0[c-1] = tx_o[0];
                s1[c-1] = tx_o[1];
            end
            s2[c-1] = tx_o[2];
            if (busy_o[2]) nb++;
        end
        check("frame_0100", 32'(s0), 32'h68);
        check("frame_odd_0000", 32'(s1), 32'h60);
        check("frame_baud3", 32'(s2), 32'hFC0FC0);
        check("busy_len_baud3", 32'(nb), 32'd21);
        vld[0] = 1'b1;
        dat[0] = 4'b0111;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) dat[0] = 4'b1111;
            if (c == 8) vld[0] = 1'b0;
            bt[c-1] = tx_o[0];
            br[c-1] = rdy_o[0];
        end
        check("b2b_tx", 32'(bt), 32'h2F6E);
        check("b2b_ready", 32'(br), 32'h2040);
        repeat (3) step();
        vld[0] = 1'b1;
        dat[0] = 4'b1010;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) vld[0] = 1'b0;
        end
        rs[0] = 1'b1;
        step();
        rs[0] = 1'b0;
        check("abort_tx", 32'(tx_o[0]), 32'd1);
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_par", 32'(par_o[0]), 32'd0);
        check("abort_ready", 32'(rdy_o[0]), 32'd1);
        repeat (4) step();
        vld[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) vld[0] = 1'b0;
            if (c <= 7) s0[c-1] = tx_o[0];
        end
        check("frame_after_abort", 32'(s0), 32'h54);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
